// File: rtl/multiplier.sv
// ============================================================================
//  Module   : multiplier
//  Purpose  : 32x32 unsigned serial-parallel shift-and-add multiplier, 64-bit
//             product after 32 iterations, with a start/done handshake.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] MP,
    input  logic [31:0] MC,
    input  logic        start,
    output logic [63:0] P,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] LAST_COUNT = 5'd31;

    state_t      state;
    state_t      state_next;

    logic [31:0] mp_sr;
    logic [31:0] mc_reg;
    logic [63:0] acc;
    logic [4:0]  count;

    logic [32:0] sum;
    logic [63:0] acc_next;
    logic        accept;
    logic        last_iter;

    // Upper half plus (MC or 0); the 33rd bit is the carry that the shift
    // brings back into the top of the partial product.
    always_comb begin
        sum       = {1'b0, acc[63:32]} + {1'b0, (mp_sr[0] ? mc_reg : 32'd0)};
        acc_next  = {sum, acc[31:1]};
        accept    = (state != BUSY) && start;
        last_iter = (state == BUSY) && (count == LAST_COUNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = BUSY;
            BUSY: if (count == LAST_COUNT) state_next = DONE;
            DONE: if (start) state_next = BUSY;
            default: state_next = IDLE;
        endcase
    end

    // P is only written at the completion edge, so it keeps the previous
    // result for the whole BUSY period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mp_sr  <= 32'd0;
            mc_reg <= 32'd0;
            acc    <= 64'd0;
            count  <= 5'd0;
            P      <= 64'd0;
            done   <= 1'b0;
        end else if (accept) begin
            mp_sr  <= MP;
            mc_reg <= MC;
            acc    <= 64'd0;
            count  <= 5'd0;
            done   <= 1'b0;
        end else if (state == BUSY) begin
            acc   <= acc_next;
            mp_sr <= {1'b0, mp_sr[31:1]};
            count <= count + 5'd1;
            if (last_iter) begin
                P    <= acc_next;
                done <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multiplier.sv
// ============================================================================
//  Module   : tb_multiplier
//  Purpose  : Self-checking bench for the serial multiplier; expected products
//             come from plain 64-bit multiplication of the accepted operands.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multiplier;

    logic        clk;
    logic        rst;
    logic [31:0] MP;
    logic [31:0] MC;
    logic        start;
    logic [63:0] P;
    logic        done;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] exp_p    = 64'd0;

    multiplier dut (
        .clk   (clk),
        .rst   (rst),
        .MP    (MP),
        .MC    (MC),
        .start (start),
        .P     (P),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Start one operation, hold start for hold_cycles cycles (accept edge
    // included), scramble the operand inputs while busy, and check latency,
    // P stability during BUSY and the final product.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int hold_cycles);
        int n;
        logic [63:0] product;
        product = 64'(a) * 64'(b);
        @(negedge clk);
        rst   = 1'b0;
        MP    = a;
        MC    = b;
        start = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_done_low_at_accept"}, 64'(done), 64'd0);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (n + 1 >= hold_cycles) start = 1'b0;
            MP = $urandom;
            MC = $urandom;
            @(posedge clk); #1;
            n++;
            if (done) break;
            if (n == 16) chk({tag, "_p_holds_busy"}, P, exp_p);
        end
        chk({tag, "_latency"}, 64'(n), 64'd32);
        chk({tag, "_product"}, P, product);
        exp_p = product;
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        MP    = 32'd0;
        MC    = 32'd0;
        #23;
        chk("reset_p", P, 64'd0);
        chk("reset_done", 64'(done), 64'd0);

        // rst deasserts in the same cycle start rises
        run_op("basic", 32'd15, 32'd7, 4);
        repeat (3) begin
            @(posedge clk); #1;
            chk("stay_done", 64'(done), 64'd1);
            chk("stay_p", P, 64'd105);
        end

        run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        chk("max_const", P, 64'hFFFF_FFFE_0000_0001);
        run_op("zero_mp", 32'd0, 32'h1234_5678, 2);
        run_op("msb_mp", 32'h8000_0000, 32'd2, 1);
        chk("msb_const", P, 64'h1_0000_0000);
        run_op("chg_ops", 32'd3, 32'd5, 1);
        chk("chg_const", P, 64'd15);

        for (int i = 0; i < 8; i++) begin
            run_op("rand", $urandom, $urandom, int'($urandom_range(1, 3)));
        end

        // Reset mid-operation
        @(negedge clk);
        MP    = 32'd1234;
        MC    = 32'd4321;
        start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_p", P, 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        exp_p = 64'd0;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
        end
        chk("idle_after_rst_done", 64'(done), 64'd0);
        chk("idle_after_rst_p", P, 64'd0);
        run_op("after_rst", 32'd6, 32'd9, 1);

        // Held start: one result every 33 cycles
        @(negedge clk);
        MP    = 32'd2;
        MC    = 32'd3;
        start = 1'b1;
        @(posedge clk); #1;
        for (int rep = 0; rep < 3; rep++) begin
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (!done && n < 40);
            chk("held_latency", 64'(n), 64'd32);
            chk("held_product", P, 64'd6);
            @(posedge clk); #1;
            chk("held_done_falls", 64'(done), 64'd0);
            chk("held_p_holds", P, 64'd6);
        end
        @(negedge clk);
        start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multiplier.md
# multiplier

32×32 unsigned serial-parallel multiplier producing a 64-bit product over 32 clock cycles. The multiplicand (MC) is applied in parallel. The multiplier (MP) is consumed serially, one bit per cycle, LSB first, using shift-and-add. It is a stand-alone arithmetic block with a start/done handshake. It trades latency for area against a combinational multiplier.

## Interface
- Parameters: none. Operand width is fixed at 32 bits and product width at 64 bits.
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- MP  input  32  multiplier operand, unsigned; sampled only when a start is accepted.
- MC  input  32  multiplicand operand, unsigned; sampled only when a start is accepted.
- start  input  1  level request to begin a multiplication.
- P  output  64  product register, unsigned, MP×MC.
- done  output  1  high while P holds a completed result.

## Operation
- The state machine has three states: IDLE, BUSY and DONE.
- IDLE: the reset state.
  - If start=1 at a rising edge, the block latches MP into a 32-bit shift register and MC into a 32-bit register.
  - On the same edge it clears the accumulator, sets the bit counter to 0 and moves to BUSY.
- BUSY: each rising edge performs one iteration.
  - If the current MP LSB is 1, add MC to the upper half of the 64-bit partial product; otherwise add 0.
  - Shift the {carry, partial product} right by 1, shift the MP register right by 1 and increment the counter.
  - After the 32nd iteration, load the final 64-bit result into P, set done=1 and move to DONE.
- DONE: P and done hold.
  - If start=1 at a rising edge, latch new operands, clear done and move to BUSY; this is the same action as in IDLE.
  - Otherwise the block stays in DONE.
- start is ignored in BUSY. Holding start high for several cycles starts exactly one operation.
  - If start is still high when the block reaches DONE, a new operation begins on the next edge.
- MP and MC may change freely after the accept edge; the result uses the latched values only.
- Arithmetic is unsigned and never overflows. The internal adder is 33 bits wide (carry kept); the maximum product is 0xFFFFFFFE_00000001.
- P keeps the previous result throughout BUSY. It updates only at the completion edge.

## Timing
- Reset (asynchronous, immediate): P=0, done=0, state IDLE, counter=0, internal registers cleared.
- Reset mid-operation aborts the computation with no partial result. After rst deasserts, the block waits in IDLE for start.
- start is sampled at rising edges only. Call the accept edge T0.
- Iterations occur at edges T0+1 through T0+32. At T0+32, P takes the product and done rises.
- Latency is 32 clock cycles from the accept edge to done=1.
- done stays high until the edge that accepts the next start, where it falls; or until reset.
- Back-to-back throughput: one result every 33 cycles if start is held high continuously, because DONE lasts one cycle before re-accepting.
- start asserted in the same cycle rst deasserts: it is accepted at the first rising edge where rst=0.

## Test plan
- Basic case: reset, MP=15, MC=7, start high for 4 cycles -> done rises exactly 32 edges after the accept edge with P=105. The block then stays in DONE once start is low.
- Maximum operands: MP=MC=0xFFFFFFFF -> P=0xFFFFFFFE00000001, done=1 after 32 cycles.
- Zero operand: MP=0, MC=0x12345678 -> P=0. Then MP=0x80000000, MC=2 -> P=0x1_00000000.
- Operand change during BUSY: start with MP=3, MC=5, then change MP/MC to 0xFFFFFFFF one cycle later -> P=15. done falls at the second accept and P holds 15 until the new completion.
- Reset mid-operation: assert rst 10 cycles after start -> P=0 and done=0 immediately. A later start with MP=6, MC=9 gives P=54 after 32 cycles.
- Held start: hold start high continuously with MP=2, MC=3 -> P=6 with done pulsing high for one cycle every 33 cycles.
